// File: rtl/imem_pkg.sv
// imem_pkg: shared types, default widths and the address legality helper
package imem_pkg;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int DEPTH_WORDS = 256;

    typedef enum logic {OWN_F, OWN_L} owner_e;
    typedef enum logic {ARB, LOCKED} state_e;

    // Word aligned and inside the memory; checked before any access is issued
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < ADDR_W'(depth));
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch port, loader port and memory macro signals of the arbiter
interface imem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 8
);

    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              f_err;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_lock;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;
    logic              l_err;

    logic              locked;

    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, f_err,
        output l_gnt, l_rvalid, l_rdata, l_err, locked,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        input  l_gnt, l_rvalid, l_rdata, l_err, locked,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_rsp_tracker.sv
// imem_rsp_tracker: remembers who was granted last cycle and steers the memory data back to that port
module imem_rsp_tracker #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_f_gnt,
    input  logic              i_l_gnt,
    input  logic              i_legal,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_f_rvalid,
    output logic              o_f_err,
    output logic [DATA_W-1:0] o_f_rdata,
    output logic              o_l_rvalid,
    output logic              o_l_err,
    output logic [DATA_W-1:0] o_l_rdata
);

    import imem_pkg::*;

    owner_e r_rsp_owner;
    logic   r_rsp_err;
    logic   r_rsp_pend;
    logic   r_rsp_rd;

    logic              w_f_own;
    logic              w_l_own;
    logic [DATA_W-1:0] w_data;

    // Capture the accepted request; a pending response lives for exactly one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_owner <= OWN_F;
            r_rsp_err   <= 1'b0;
            r_rsp_pend  <= 1'b0;
            r_rsp_rd    <= 1'b0;
        end else begin
            r_rsp_owner <= i_l_gnt ? OWN_L : (i_f_gnt ? OWN_F : r_rsp_owner);
            r_rsp_err   <= (i_f_gnt | i_l_gnt) & ~i_legal;
            r_rsp_pend  <= i_f_gnt | i_l_gnt;
            r_rsp_rd    <= (i_f_gnt | i_l_gnt) & i_legal & ~(i_l_gnt & i_we);
        end
    end

    // Only a legal read returns memory data; writes and errors return zero
    always_comb begin
        w_f_own    = r_rsp_pend & (r_rsp_owner == OWN_F);
        w_l_own    = r_rsp_pend & (r_rsp_owner == OWN_L);
        w_data     = r_rsp_rd ? i_mem_rdata : '0;
        o_f_rvalid = w_f_own;
        o_f_err    = w_f_own & r_rsp_err;
        o_f_rdata  = w_f_own ? w_data : '0;
        o_l_rvalid = w_l_own;
        o_l_err    = w_l_own & r_rsp_err;
        o_l_rdata  = w_l_own ? w_data : '0;
    end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one synchronous instruction memory between CPU fetch (F) and a loader (L)
module imem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int MAX_WAIT    = 4,
    localparam int MEM_AW     = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_arbiter_if.slave bus
);

    import imem_pkg::*;

    localparam int WC_W = $clog2(MAX_WAIT + 1);

    state_e          r_state;
    logic            r_locked;
    logic [WC_W-1:0] r_wait_cnt;

    logic              w_starved;
    logic              w_f_gnt;
    logic              w_l_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic              w_legal;
    logic              w_mem_en;
    logic              w_mem_we;

    // L wins when locked, when F is idle, or once it has been passed over MAX_WAIT times
    always_comb begin
        w_starved = r_wait_cnt == WC_W'(MAX_WAIT);
        w_l_gnt   = rst_n & bus.l_req & ((r_state == LOCKED) | ~bus.f_req | w_starved);
        w_f_gnt   = rst_n & bus.f_req & (r_state == ARB) & ~w_l_gnt;
        w_addr    = w_l_gnt ? bus.l_addr : bus.f_addr;
        w_legal   = addr_legal(w_addr, DEPTH_WORDS);
        w_mem_en  = (w_f_gnt | w_l_gnt) & w_legal;
        w_mem_we  = w_mem_en & w_l_gnt & bus.l_we;
    end

    assign bus.f_gnt     = w_f_gnt;
    assign bus.l_gnt     = w_l_gnt;
    assign bus.locked    = r_locked;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_en ? w_addr[MEM_AW+1:2] : '0;
    assign bus.mem_wdata = w_mem_we ? bus.l_wdata : '0;

    // Lock state follows l_lock one cycle later; wait_cnt counts how long L has been passed over
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB;
            r_locked   <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state  <= bus.l_lock ? LOCKED : ARB;
            r_locked <= bus.l_lock;
            if (w_l_gnt || (r_state == ARB && bus.l_lock))
                r_wait_cnt <= '0;
            else if (bus.l_req && !w_starved)
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    imem_rsp_tracker #(
        .DATA_W (DATA_W)
    ) u_rsp (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_f_gnt     (w_f_gnt),
        .i_l_gnt     (w_l_gnt),
        .i_legal     (w_legal),
        .i_we        (bus.l_we),
        .i_mem_rdata (bus.mem_rdata),
        .o_f_rvalid  (bus.f_rvalid),
        .o_f_err     (bus.f_err),
        .o_f_rdata   (bus.f_rdata),
        .o_l_rvalid  (bus.l_rvalid),
        .o_l_err     (bus.l_err),
        .o_l_rdata   (bus.l_rdata)
    );

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed and random checks of imem_arbiter against a transaction-level model
module tb_imem_arbiter;

    localparam int DEPTH    = 256;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_clear;

    always #5 clk = ~clk;

    imem_arbiter_if #(.DATA_W(32), .ADDR_W(32), .MEM_AW(8)) bus ();

    imem_arbiter #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .DEPTH_WORDS (DEPTH),
        .MAX_WAIT    (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural memory macro: one-cycle synchronous read
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    bit  m_locked;
    int  m_wait;
    bit  e_frv, e_ferr, e_lrv, e_lerr;
    logic [31:0] e_frd, e_lrd;
    bit  exp_f, exp_l;
    logic obs_f, obs_l, obs_men;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_wait = 0;
        {e_frv, e_ferr, e_lrv, e_lerr} = '0;
        e_frd = '0;
        e_lrd = '0;
        exp_f = 0;
        exp_l = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_f_gnt"}, bus.f_gnt, 0);
        chk({tag, "_f_rvalid"}, bus.f_rvalid, 0);
        chk({tag, "_f_rdata"}, bus.f_rdata, 0);
        chk({tag, "_f_err"}, bus.f_err, 0);
        chk({tag, "_l_gnt"}, bus.l_gnt, 0);
        chk({tag, "_l_rvalid"}, bus.l_rvalid, 0);
        chk({tag, "_l_rdata"}, bus.l_rdata, 0);
        chk({tag, "_l_err"}, bus.l_err, 0);
        chk({tag, "_locked"}, bus.locked, 0);
        chk({tag, "_mem_en"}, bus.mem_en, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    // One clock cycle: drive inputs, check grants/memory/responses against the model, advance the model
    task automatic step(input logic fr, input logic [31:0] fa, input logic lr, input logic lw,
                        input logic [31:0] la, input logic [31:0] ld, input logic lk);
        bit legal, acc;
        logic [31:0] a;
        bus.f_req = fr;
        bus.f_addr = fa;
        bus.l_req = lr;
        bus.l_we = lw;
        bus.l_addr = la;
        bus.l_wdata = ld;
        bus.l_lock = lk;
        @(negedge clk);
        exp_l = lr && (m_locked || !fr || m_wait == MAX_WAIT);
        exp_f = fr && !m_locked && !exp_l;
        a = exp_l ? la : fa;
        legal = (a % 4 == 0) && (a / 4 < DEPTH);
        acc = exp_f || exp_l;
        obs_f = bus.f_gnt;
        obs_l = bus.l_gnt;
        obs_men = bus.mem_en;
        chk("f_gnt", bus.f_gnt, exp_f);
        chk("l_gnt", bus.l_gnt, exp_l);
        chk("mem_en", bus.mem_en, acc && legal);
        if (acc && legal) begin
            chk("mem_addr", 32'(bus.mem_addr), a / 4);
            chk("mem_we", bus.mem_we, exp_l && lw);
            chk("mem_wdata", bus.mem_wdata, (exp_l && lw) ? ld : 32'h0);
        end
        chk("locked", bus.locked, m_locked);
        chk("f_rvalid", bus.f_rvalid, e_frv);
        chk("f_err", bus.f_err, e_ferr);
        chk("f_rdata", bus.f_rdata, e_frd);
        chk("l_rvalid", bus.l_rvalid, e_lrv);
        chk("l_err", bus.l_err, e_lerr);
        chk("l_rdata", bus.l_rdata, e_lrd);
        @(posedge clk);
        e_frv = exp_f;
        e_ferr = exp_f && !legal;
        e_frd = (exp_f && legal) ? ref_mem[a / 4] : 32'h0;
        e_lrv = exp_l;
        e_lerr = exp_l && !legal;
        e_lrd = (exp_l && legal && !lw) ? ref_mem[a / 4] : 32'h0;
        if (exp_l && legal && lw) ref_mem[a / 4] = ld;
        if (exp_l || lk) m_wait = 0;
        else if (lr && m_wait < MAX_WAIT) m_wait++;
        m_locked = lk;
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        if (k == 1) return ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFC : 32'(DEPTH * 4) + 32'($urandom_range(0, 100)) * 4;
        return 32'($urandom_range(0, 15)) * 4;
    endfunction

    logic [31:0] words [4];
    logic obs_fs [6];
    int  fcnt, lstep;
    bit  lgot;
    logic fr, lr, lw, lk;
    logic [31:0] fa, la, ld;

    initial begin
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        words[2] = 32'h0020_0113;
        words[3] = 32'h0030_0193;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        model_reset();
        rst_n = 1'b0;
        mem_clear = 1'b1;
        bus.f_req = 0; bus.f_addr = 0; bus.l_req = 0; bus.l_we = 0;
        bus.l_addr = 0; bus.l_wdata = 0; bus.l_lock = 0;
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        mem_clear = 1'b0;
        rst_n = 1'b1;

        // Preload through the loader, then fetch back-to-back
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 32'(i * 4), words[i], 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 32'(i * 4), 0, 0, 0, 0, 0);
            chk("fetch_gnt", obs_f, 1);
            chk("fetch_rvalid", bus.f_rvalid, 1);
            chk("fetch_rdata", bus.f_rdata, words[i]);
            chk("fetch_err", bus.f_err, 0);
        end

        // Contention: L is forced ahead after MAX_WAIT losses
        fcnt = 0; lstep = -1; lgot = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, !lgot, 0, 32'h10, 0, 0);
            obs_fs[i] = obs_f;
            if (i < 4) fcnt += int'(obs_f);
            if (obs_l && !lgot) begin lgot = 1; lstep = i; end
        end
        chk("starve_f_wins", fcnt, 4);
        chk("starve_l_step", lstep, 4);
        chk("starve_f_held_off", obs_fs[4], 0);
        chk("starve_f_resume", obs_fs[5], 1);

        // Lock and load
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 32'h20, 1, 1, 32'h20, 32'hDEAD_BEEF, 1);
        chk("lock_f_gnt", obs_f, 0);
        chk("lock_l_gnt", obs_l, 1);
        chk("lock_locked", bus.locked, 1);
        chk("lock_ack_rvalid", bus.l_rvalid, 1);
        chk("lock_ack_rdata", bus.l_rdata, 0);
        step(1, 32'h20, 0, 0, 0, 0, 1);
        chk("lock_f_gnt2", obs_f, 0);
        step(1, 32'h20, 0, 0, 0, 0, 0);
        chk("lock_f_gnt3", obs_f, 0);
        step(1, 32'h20, 0, 0, 0, 0, 0);
        chk("unlock_f_gnt", obs_f, 1);
        chk("unlock_rdata", bus.f_rdata, 32'hDEAD_BEEF);

        // Illegal addresses: misaligned and one past the end
        step(1, 32'h2, 0, 0, 0, 0, 0);
        chk("err_mis_mem_en", obs_men, 0);
        chk("err_mis_rvalid", bus.f_rvalid, 1);
        chk("err_mis_err", bus.f_err, 1);
        chk("err_mis_rdata", bus.f_rdata, 0);
        step(1, 32'(DEPTH * 4), 0, 0, 0, 0, 0);
        chk("err_oor_mem_en", obs_men, 0);
        chk("err_oor_rvalid", bus.f_rvalid, 1);
        chk("err_oor_err", bus.f_err, 1);
        chk("err_oor_rdata", bus.f_rdata, 0);

        // Reset in the cycle after a fetch grant drops the response
        step(1, 0, 0, 0, 0, 0, 0);
        bus.f_req = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rvalid", bus.f_rvalid, 0);
        @(negedge clk);
        chk_all_zero("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_rvalid", bus.f_rvalid, 1);
        chk("post_rst_rdata", bus.f_rdata, 32'h0000_0013);

        // Random traffic; requests stay stable until granted
        fr = 0; lr = 0; lw = 0; lk = 0; fa = 0; la = 0; ld = 0;
        for (int i = 0; i < 600; i++) begin
            if (!(fr && !exp_f)) begin
                fr = 1'($urandom_range(0, 1));
                fa = rand_addr();
            end
            if (!(lr && !exp_l)) begin
                lr = 1'($urandom_range(0, 1));
                lw = 1'($urandom_range(0, 1));
                la = rand_addr();
                ld = $urandom;
            end
            if ($urandom_range(0, 15) == 0) lk = !lk;
            step(fr, fa, lr, lw, la, ld, lk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-ported synchronous instruction memory between two requesters.
  - Port F: CPU fetch, read-only.
  - Port L: program loader/debug, read/write.
- Provides fixed fetch priority with a starvation guard for L.
- Provides an exclusive loader lock so a program image can be written while fetch is held off.
- Checks alignment and range before any memory access.
- Sits between the core fetch stage / loader and the instruction memory macro.

Parameters:
DATA_W, 32, instruction/data word width
ADDR_W, 32, byte address width on both requester ports
DEPTH_WORDS, 256, memory depth in words; MEM_AW = clog2(DEPTH_WORDS)
MAX_WAIT, 4, cycles L may wait while F wins before L is forced ahead

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
f_req  in  1  fetch request
f_addr  in  ADDR_W  fetch byte address
f_gnt  out  1  fetch request accepted this cycle
f_rvalid  out  1  fetch response valid, one-cycle pulse
f_rdata  out  DATA_W  fetched instruction
f_err  out  1  fetch response is an error (qualified by f_rvalid)
l_req  in  1  loader request
l_we  in  1  loader write enable
l_addr  in  ADDR_W  loader byte address
l_wdata  in  DATA_W  loader write data
l_lock  in  1  loader requests exclusive ownership
l_gnt  out  1  loader request accepted this cycle
l_rvalid  out  1  loader response or write acknowledge, one-cycle pulse
l_rdata  out  DATA_W  loader read data
l_err  out  1  loader response is an error
locked  out  1  arbiter is in LOCKED state
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  MEM_AW  memory word index
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: every output 0; state=ARB; wait_cnt=0; rsp_owner=F; rsp_err=0; rsp_pend=0.
  - Reset asserted mid-operation drops any outstanding response; no rvalid follows.
- Handshake:
  - A request is accepted when req & gnt are both high.
  - gnt is combinational from req, state and wait_cnt.
  - A requester holds req, addr, we and wdata stable until gnt.
  - Back-to-back accepts are allowed every cycle.
- Latency: exactly 1 cycle. rvalid of the accepted port pulses in the cycle after gnt.
- Legality check at accept:
  - legal = (addr[1:0]==0) and (addr[ADDR_W-1:2] < DEPTH_WORDS).
  - Illegal request: still granted; mem_en=0; next cycle rvalid=1, err=1, rdata=0.
- Legal grant drives the memory in the same cycle:
  - mem_en=1, mem_addr=addr[MEM_AW+1:2].
  - mem_we = l_we for L, 0 for F; mem_wdata = l_wdata for an L write, else 0.
- Response data:
  - rdata = mem_rdata for a legal read.
  - rdata = 0 for a write acknowledge and for error responses.
  - Non-owning port rdata = 0.
- FSM:
  - ARB -> LOCKED when l_lock=1; takes effect the next cycle.
  - LOCKED -> ARB when l_lock=0; takes effect the next cycle.
  - A fetch granted in the same cycle l_lock rises still completes its response.
- Arbitration in ARB:
  - Only one port requesting: that port wins.
  - Both requesting: F wins unless wait_cnt==MAX_WAIT, in which case L wins.
- Arbitration in LOCKED: f_gnt=0; L is granted whenever l_req=1.
- wait_cnt:
  - Increments in each cycle with l_req & !l_gnt, saturating at MAX_WAIT.
  - Clears on l_gnt and on entry to LOCKED.
- At most one gnt per cycle. mem_en=1 only for a legal accepted request.

Decomposition:
- Package imem_pkg holds:
  - Owner enum {OWN_F, OWN_L} and state enum {ARB, LOCKED}.
  - DATA_W, ADDR_W and DEPTH_WORDS defaults.
  - The addr_legal function.
- Sub-module imem_rsp_tracker: registers rsp_owner/rsp_err/rsp_pend and steers mem_rdata to f_/l_ response outputs.
- Arbitration, FSM and wait counter stay in the top level.

Test Plan:
- Basic fetch: preload mem[0..3] = 00000013, 00100093, 00200113, 00300193; F reads addr 0,4,8,12 back-to-back -> f_gnt high every cycle; f_rvalid one cycle later with exactly those words; f_err=0.
- Contention and starvation: f_req held high and l_req held high with addr 0x10 -> F granted 4 cycles; 5th cycle l_gnt=1, f_gnt=0; wait_cnt returns to 0; F resumes the next cycle.
- Lock and load: l_lock=1; L writes 0xDEADBEEF to 0x20 -> locked=1 next cycle; f_gnt=0 throughout; l_rvalid ack with l_rdata=0. Drop l_lock, F reads 0x20 -> f_rdata=DEADBEEF.
- Errors: F addr 0x2 and addr DEPTH_WORDS*4 -> mem_en=0; f_rvalid=1, f_err=1, f_rdata=0 one cycle after each grant.
- Reset mid-flight: rst_n low in the cycle after f_gnt -> f_rvalid stays 0; all outputs 0; state ARB. After release a fresh fetch of addr 0 returns 00000013.
